// File: rtl/fde_machine.sv
// Fetch/decode/execute phase sequencer with per-phase dwell counts and an en-qualified end-of-instruction pulse.
// Latency: one phase per N_phase enabled clocks. When en is low, the phase and the dwell count hold.
module fde_machine #(
  parameter int FETCH_CYCLES   = 1,
  parameter int DECODE_CYCLES  = 1,
  parameter int EXECUTE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       fetch,
  output logic       decode,
  output logic       execute,
  output logic [1:0] state,
  output logic       instr_done
);

  localparam int NF   = (FETCH_CYCLES   < 1) ? 1 : FETCH_CYCLES;
  localparam int ND   = (DECODE_CYCLES  < 1) ? 1 : DECODE_CYCLES;
  localparam int NE   = (EXECUTE_CYCLES < 1) ? 1 : EXECUTE_CYCLES;
  localparam int NMAX = (NF > ND) ? ((NF > NE) ? NF : NE) : ((ND > NE) ? ND : NE);
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic [CW-1:0] F_LAST = CW'(NF - 1);
  localparam logic [CW-1:0] D_LAST = CW'(ND - 1);
  localparam logic [CW-1:0] E_LAST = CW'(NE - 1);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DECODE  = 2'b01,
    EXECUTE = 2'b10,
    ILLEGAL = 2'b11
  } phase_t;

  // Held as plain bits so an unreachable encoding stays observable and recoverable.
  logic [1:0]    state_r;
  phase_t        state_nxt;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] last_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      count_r <= '0;
    end else begin
      state_r <= state_nxt;
      count_r <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = phase_t'(state_r);
    count_nxt  = count_r;
    last_count = F_LAST;
    fetch      = 1'b0;
    decode     = 1'b0;
    execute    = 1'b0;
    case (phase_t'(state_r))
      FETCH: begin
        fetch      = 1'b1;
        last_count = F_LAST;
      end
      DECODE: begin
        decode     = 1'b1;
        last_count = D_LAST;
      end
      EXECUTE: begin
        execute    = 1'b1;
        last_count = E_LAST;
      end
      default: last_count = F_LAST;
    endcase

    if (state_r == ILLEGAL) begin
      state_nxt = FETCH;
      count_nxt = '0;
    end else if (en) begin
      if (count_r == last_count) begin
        count_nxt = '0;
        case (phase_t'(state_r))
          FETCH:   state_nxt = DECODE;
          DECODE:  state_nxt = EXECUTE;
          default: state_nxt = FETCH;
        endcase
      end else begin
        count_nxt = count_r + CW'(1);
      end
    end
  end

  assign state      = state_r;
  assign instr_done = en && (state_r == EXECUTE) && (count_r == E_LAST);

endmodule

// File: tb/tb_fde_machine.sv
// Directed bench for fde_machine: a default-parameter instance and one with a 3-clock EXECUTE phase.
module tb_fde_machine;

  logic       clk = 1'b0;
  logic       reset, en, reset3, en3;
  logic       fetch, decode, execute, instr_done;
  logic [1:0] state;
  logic       fetch3, decode3, execute3, instr_done3;
  logic [1:0] state3;
  int         checks = 0;
  int         failures = 0;

  // {fetch, decode, execute, state, instr_done}
  wire [5:0] obs  = {fetch, decode, execute, state, instr_done};
  wire [5:0] obs3 = {fetch3, decode3, execute3, state3, instr_done3};

  localparam logic [5:0] S_F  = 6'b100_00_0;
  localparam logic [5:0] S_D  = 6'b010_01_0;
  localparam logic [5:0] S_E  = 6'b001_10_0;
  localparam logic [5:0] S_ED = 6'b001_10_1;

  fde_machine dut (
    .clk(clk), .reset(reset), .en(en),
    .fetch(fetch), .decode(decode), .execute(execute),
    .state(state), .instr_done(instr_done)
  );

  fde_machine #(.EXECUTE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset3), .en(en3),
    .fetch(fetch3), .decode(decode3), .execute(execute3),
    .state(state3), .instr_done(instr_done3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; reset3 = 1'b1; en3 = 1'b0;
    step();
    step();
    checks++;
    if (obs !== S_F) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, S_F);
    end
    checks++;
    if (obs3 !== S_F) begin
      failures++;
      $display("FAIL reset_state3 got=%b want=%b", obs3, S_F);
    end
    reset3 = 1'b0;
  endtask

  task automatic test_sequence();
    logic [5:0] exp [5];
    exp[0] = S_F; exp[1] = S_D; exp[2] = S_ED; exp[3] = S_F; exp[4] = S_D;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL sequence[%0d] got=%b want=%b", i, obs, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== S_D) begin
        failures++;
        $display("FAIL hold[%0d] got=%b want=%b", i, obs, S_D);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (obs !== S_ED) begin
      failures++;
      $display("FAIL hold_resume got=%b want=%b", obs, S_ED);
    end
  endtask

  task automatic test_long_execute();
    logic [5:0] exp [5];
    exp[0] = S_D; exp[1] = S_E; exp[2] = S_E; exp[3] = S_ED; exp[4] = S_F;
    reset3 = 1'b1; en3 = 1'b0;
    step();
    reset3 = 1'b0; en3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs3 !== exp[i]) begin
        failures++;
        $display("FAIL long_execute[%0d] got=%b want=%b", i, obs3, exp[i]);
      end
      // Mid-run pause at the last execute count: done must drop with en.
      if (i == 3) begin
        en3 = 1'b0;
        #1;
        checks++;
        if (obs3 !== S_E) begin
          failures++;
          $display("FAIL long_execute_paused got=%b want=%b", obs3, S_E);
        end
        step();
        en3 = 1'b1;
        #1;
        checks++;
        if (obs3 !== S_ED) begin
          failures++;
          $display("FAIL long_execute_resumed got=%b want=%b", obs3, S_ED);
        end
      end
    end
  endtask

  task automatic test_reset_mid_phase();
    do_reset();
    en = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (obs !== S_F) begin
      failures++;
      $display("FAIL reset_in_execute_en1 got=%b want=%b", obs, S_F);
    end
    // Abandon dut3 part-way through its long execute phase with en low.
    reset3 = 1'b0; en3 = 1'b1;
    step(); step(); step();
    en3 = 1'b0; reset3 = 1'b1;
    step();
    checks++;
    if (obs3 !== S_F) begin
      failures++;
      $display("FAIL reset_in_execute_en0 got=%b want=%b", obs3, S_F);
    end
    reset3 = 1'b0; en3 = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (obs3 !== S_ED) begin
      failures++;
      $display("FAIL reset_clears_count got=%b want=%b", obs3, S_ED);
    end
    reset = 1'b0;
  endtask

  task automatic test_illegal();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      if (pass == 1) begin
        en = 1'b1;
        step(); step();
      end
      force dut.state_r = 2'b11;
      #1;
      checks++;
      if (obs !== 6'b000_11_0) begin
        failures++;
        $display("FAIL illegal_outputs[en=%0d] got=%b want=%b", pass, obs, 6'b000_11_0);
      end
      release dut.state_r;
      step();
      checks++;
      if (obs !== S_F) begin
        failures++;
        $display("FAIL illegal_recover[en=%0d] got=%b want=%b", pass, obs, S_F);
      end
      en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int bad   = 0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      checks++;
      if ($countones({fetch, decode, execute}) != 1) begin
        failures++;
        bad++;
        if (bad < 4) $display("FAIL onehot[%0d] got=%b want=one-hot", i, {fetch, decode, execute});
      end
      if (instr_done) dones++;
      step();
    end
    checks++;
    if (dones != 100) begin
      failures++;
      $display("FAIL done_count got=%0d want=100", dones);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_long_execute();
    test_reset_mid_phase();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
